branch_fetch_unit: RTL and testbench

Fetch-stage next-PC generator that sits directly upstream of the branch predictor. It drives the instruction-memory/predictor fetch address and consumes the predictor's taken bit together with a direct-mapped branch target buffer (BTB) to steer fetch. On a misprediction resolved in the ALU stage, it redirects fetch and raises a same-cycle flush to the front-end pipeline registers.

---
 rtl/branch_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_branch_fetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_fetch_unit.sv
// Fetch next-PC generator: direct-mapped BTB steering plus ALU-resolved redirect (BRANCH_FETCH_STATS_EN adds counters).
// Latency: next PC registered each cycle, redirect visible one cycle after the mispredict; o_Flush same cycle.
// Backpressure: i_Stall holds the PC unless a mispredict redirect is pending, which always wins.
module branch_fetch_unit #(
    parameter int                       ADDRESS_WIDTH = 22,
    parameter int                       BTB_INDEX     = 6,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset,
    input  logic                     i_Stall,
    input  logic                     i_Pred_taken,
    input  logic                     i_ALU_isbranch,
    input  logic                     i_ALU_outcome,
    input  logic                     i_ALU_prediction,
    input  logic [ADDRESS_WIDTH-1:0] i_ALU_pred_target,
    input  logic [ADDRESS_WIDTH-1:0] i_ALU_pc,
    input  logic [ADDRESS_WIDTH-1:0] i_ALU_target,
    output logic [ADDRESS_WIDTH-1:0] o_PC,
    output logic                     o_PC_valid,
    output logic                     o_Pred_taken,
    output logic [ADDRESS_WIDTH-1:0] o_Pred_target,
    output logic                     o_Flush
`ifdef BRANCH_FETCH_STATS_EN
    ,
    output logic [31:0]              o_Branch_count,
    output logic [31:0]              o_Mispredict_count
`endif
);

    localparam int TAG_W       = ADDRESS_WIDTH - BTB_INDEX;
    localparam int BTB_ENTRIES = 1 << BTB_INDEX;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [ADDRESS_WIDTH-1:0] PC_ONE  = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [BTB_INDEX-1:0]     IDX_ONE = {{(BTB_INDEX-1){1'b0}}, 1'b1};

    logic [0:0]               state_q, state_d;
    logic [BTB_INDEX-1:0]     clr_idx_q, clr_idx_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;

    logic                     btb_vld_q [BTB_ENTRIES];
    logic [TAG_W-1:0]         btb_tag_q [BTB_ENTRIES];
    logic [ADDRESS_WIDTH-1:0] btb_tgt_q [BTB_ENTRIES];

    logic                     run;
    logic                     hit;
    logic                     pred_hit;
    logic                     mispredict;
    logic                     btb_we;
    logic [BTB_INDEX-1:0]     rd_idx;
    logic [BTB_INDEX-1:0]     wr_idx;
    logic [ADDRESS_WIDTH-1:0] pc_inc;
    logic [ADDRESS_WIDTH-1:0] seq_next;
    logic [ADDRESS_WIDTH-1:0] redirect_pc;

    assign run    = (state_q == ST_RUN);
    assign rd_idx = pc_q[BTB_INDEX-1:0];
    assign wr_idx = i_ALU_pc[BTB_INDEX-1:0];

    // Gated by run so uncleared valid bits can never steer fetch during INIT.
    assign hit      = btb_vld_q[rd_idx] && (btb_tag_q[rd_idx] == pc_q[ADDRESS_WIDTH-1:BTB_INDEX]);
    assign pred_hit = run && i_Pred_taken && hit;
    assign pc_inc   = pc_q + PC_ONE;
    assign seq_next = pred_hit ? btb_tgt_q[rd_idx] : pc_inc;

    assign mispredict  = i_ALU_isbranch &&
                         ((i_ALU_outcome != i_ALU_prediction) ||
                          (i_ALU_outcome && i_ALU_prediction && (i_ALU_pred_target != i_ALU_target)));
    assign redirect_pc = i_ALU_outcome ? i_ALU_target : (i_ALU_pc + PC_ONE);
    assign btb_we      = run && !i_Reset && i_ALU_isbranch && i_ALU_outcome;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        pc_d      = pc_q;
        if (!run) begin
            clr_idx_d = clr_idx_q + IDX_ONE;
            pc_d      = RESET_PC;
            if (clr_idx_q == {BTB_INDEX{1'b1}}) begin
                state_d = ST_RUN;
            end
        end else if (mispredict) begin
            pc_d = redirect_pc;
        end else if (!i_Stall) begin
            pc_d = seq_next;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q   <= ST_INIT;
            clr_idx_q <= '0;
            pc_q      <= RESET_PC;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            pc_q      <= pc_d;
        end
    end

    // Writes land at the edge, so a same-cycle lookup of that index still sees the old entry.
    always_ff @(posedge i_Clk) begin
        if (!run && !i_Reset) begin
            btb_vld_q[clr_idx_q] <= 1'b0;
        end else if (btb_we) begin
            btb_vld_q[wr_idx] <= 1'b1;
            btb_tag_q[wr_idx] <= i_ALU_pc[ADDRESS_WIDTH-1:BTB_INDEX];
            btb_tgt_q[wr_idx] <= i_ALU_target;
        end
    end

    assign o_PC          = pc_q;
    assign o_PC_valid    = run;
    assign o_Pred_taken  = pred_hit;
    assign o_Pred_target = seq_next;
    assign o_Flush       = run && mispredict;

`ifdef BRANCH_FETCH_STATS_EN
    logic [31:0] br_cnt_q;
    logic [31:0] mp_cnt_q;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else if (run) begin
            if (i_ALU_isbranch && (br_cnt_q != 32'hFFFF_FFFF)) begin
                br_cnt_q <= br_cnt_q + 32'd1;
            end
            if (mispredict && (mp_cnt_q != 32'hFFFF_FFFF)) begin
                mp_cnt_q <= mp_cnt_q + 32'd1;
            end
        end
    end

    assign o_Branch_count     = br_cnt_q;
    assign o_Mispredict_count = mp_cnt_q;
`endif

endmodule

// File: tb/tb_branch_fetch_unit.sv
// Scoreboard bench for branch_fetch_unit: expected next PCs queued at drive time, popped after the edge.
module tb_branch_fetch_unit;

    localparam int AW = 22;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          pred_taken;
    logic          alu_isbr;
    logic          alu_out;
    logic          alu_pred;
    logic [AW-1:0] alu_pred_tgt;
    logic [AW-1:0] alu_pc;
    logic [AW-1:0] alu_tgt;
    logic [AW-1:0] pc;
    logic          pc_valid;
    logic          pred_taken_o;
    logic [AW-1:0] pred_tgt;
    logic          flush;
`ifdef BRANCH_FETCH_STATS_EN
    logic [31:0]   br_cnt;
    logic [31:0]   mp_cnt;
`endif

    always #5 clk = ~clk;

    branch_fetch_unit dut (
        .i_Clk             (clk),
        .i_Reset           (rst),
        .i_Stall           (stall),
        .i_Pred_taken      (pred_taken),
        .i_ALU_isbranch    (alu_isbr),
        .i_ALU_outcome     (alu_out),
        .i_ALU_prediction  (alu_pred),
        .i_ALU_pred_target (alu_pred_tgt),
        .i_ALU_pc          (alu_pc),
        .i_ALU_target      (alu_tgt),
        .o_PC              (pc),
        .o_PC_valid        (pc_valid),
        .o_Pred_taken      (pred_taken_o),
        .o_Pred_target     (pred_tgt),
        .o_Flush           (flush)
`ifdef BRANCH_FETCH_STATS_EN
        ,
        .o_Branch_count    (br_cnt),
        .o_Mispredict_count(mp_cnt)
`endif
    );

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [AW-1:0] exp_q [$];

    logic [AW-1:0] model_pc;
    logic          m_vld [64];
    logic [15:0]   m_tag [64];
    logic [AW-1:0] m_tgt [64];
    int            m_br;
    int            m_mp;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive_idle();
        stall = 1'b0; pred_taken = 1'b0; alu_isbr = 1'b0; alu_out = 1'b0; alu_pred = 1'b0;
        alu_pred_tgt = '0; alu_pc = '0; alu_tgt = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) m_vld[i] = 1'b0;
        model_pc = '0;
        m_br = 0;
        m_mp = 0;
    endtask

    // One RUN cycle; starts and ends just after a falling edge.
    task automatic step(input string tag, input logic st, input logic pt, input logic ib,
                        input logic oc, input logic pd, input logic [AW-1:0] ptg,
                        input logic [AW-1:0] bpc, input logic [AW-1:0] btg);
        logic          hit;
        logic          mp;
        logic [AW-1:0] seq;
        logic [AW-1:0] nxt;
        logic [AW-1:0] e;
        int            ri;
        int            wi;
        stall = st; pred_taken = pt; alu_isbr = ib; alu_out = oc; alu_pred = pd;
        alu_pred_tgt = ptg; alu_pc = bpc; alu_tgt = btg;
        #1;
        ri  = int'(model_pc[5:0]);
        hit = m_vld[ri] && (m_tag[ri] == model_pc[AW-1:6]);
        mp  = ib && ((oc != pd) || (oc && pd && (ptg != btg)));
        seq = (pt && hit) ? m_tgt[ri] : model_pc + 22'd1;
        nxt = mp ? (oc ? btg : bpc + 22'd1) : (st ? model_pc : seq);
        chk({tag, ".valid"}, 64'(pc_valid), 64'(1'b1));
        chk({tag, ".pc"}, 64'(pc), 64'(model_pc));
        chk({tag, ".flush"}, 64'(flush), 64'(mp));
        chk({tag, ".ptaken"}, 64'(pred_taken_o), 64'(pt && hit));
        chk({tag, ".ptarget"}, 64'(pred_tgt), 64'(seq));
        if (ib) m_br++;
        if (mp) m_mp++;
        if (ib && oc) begin
            wi = int'(bpc[5:0]);
            m_vld[wi] = 1'b1;
            m_tag[wi] = bpc[AW-1:6];
            m_tgt[wi] = btg;
        end
        exp_q.push_back(nxt);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 64'(1'b1), 64'(1'b0));
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".next"}, 64'(pc), 64'(e));
            model_pc = e;
        end
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // Not-taken branch predicted taken: redirects to pc+1 without touching the BTB.
    task automatic redirect(input string tag, input logic [AW-1:0] addr);
        step(tag, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, '0, addr - 22'd1, '0);
    endtask

    task automatic do_reset(input string tag, input int ncyc);
        rst = 1'b1;
        drive_idle();
        repeat (ncyc) @(posedge clk);
        #1;
        chk({tag, ".rst_pc"}, 64'(pc), 64'(0));
        chk({tag, ".rst_valid"}, 64'(pc_valid), 64'(0));
        chk({tag, ".rst_flush"}, 64'(flush), 64'(0));
        chk({tag, ".rst_ptaken"}, 64'(pred_taken_o), 64'(0));
        chk({tag, ".rst_ptarget"}, 64'(pred_tgt), 64'(1));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i == 10) begin
                alu_isbr = 1'b1; alu_out = 1'b1; alu_pred = 1'b0;
                alu_pc = 22'h3; alu_tgt = 22'h77; stall = 1'b1;
            end else begin
                drive_idle();
            end
            #1;
            chk({tag, ".init_valid"}, 64'(pc_valid), 64'(0));
            chk({tag, ".init_pc"}, 64'(pc), 64'(0));
            if (i == 10) chk({tag, ".init_noflush"}, 64'(flush), 64'(0));
            @(negedge clk);
        end
        drive_idle();
        model_clear();
`ifdef BRANCH_FETCH_STATS_EN
        chk({tag, ".br_cnt0"}, 64'(br_cnt), 64'(0));
        chk({tag, ".mp_cnt0"}, 64'(mp_cnt), 64'(0));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_clear();
        do_reset("por", 2);
        idle("seq0");
        idle("seq1");
        chk("seq.pc2", 64'(pc), 64'(22'h2));

        step("br10", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 22'h10, 22'h40);
        chk("br10.pc40", 64'(pc), 64'(22'h40));
        redirect("to10", 22'h10);
        step("hit10", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        chk("hit10.pc40", 64'(pc), 64'(22'h40));
        step("ok_taken", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 22'h40, 22'h10, 22'h40);
        step("bad_tgt", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 22'h41, 22'h10, 22'h40);

        redirect("to30", 22'h30);
        step("miss30", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        chk("miss30.pc31", 64'(pc), 64'(22'h31));

        step("nt20", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, '0, 22'h20, 22'h99);
        chk("nt20.pc21", 64'(pc), 64'(22'h21));
        redirect("to20", 22'h20);
        step("miss20", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);

        redirect("to08", 22'h08);
        for (int i = 0; i < 3; i++) step("stall", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        chk("stall.pc08", 64'(pc), 64'(22'h08));
        step("stall_mp", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0, 22'h200, 22'h50);
        chk("stall_mp.pc50", 64'(pc), 64'(22'h50));

        redirect("to_top", 22'h3FFFFF);
        idle("wrap");
        chk("wrap.pc0", 64'(pc), 64'(0));

        // Mid-run reset: BTB must be cleared again, counters restart.
        do_reset("mid", 1);
        redirect("s_b1", 22'h10);
        step("s_miss10", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        step("s_b2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 22'h11, '0);
        step("s_b3", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 22'h80, 22'h12, 22'h80);
        step("s_b4", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 22'h13, '0);
        step("s_b5", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 22'h14, 22'h90);
`ifdef BRANCH_FETCH_STATS_EN
        chk("stats.br", 64'(br_cnt), 64'(m_br));
        chk("stats.mp", 64'(mp_cnt), 64'(m_mp));
        chk("stats.br5", 64'(br_cnt), 64'(5));
        chk("stats.mp2", 64'(mp_cnt), 64'(2));
`endif
        chk("sb.drained", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
